// File: rtl/rr_bus_arbiter.sv
// Round-robin / fixed-priority bus arbiter for the i2d intercon masters.
// Registered one-hot grant with ownership hold and hold-time preemption.
`ifndef INTERCON_MASTER_NUM
`define INTERCON_MASTER_NUM 4
`endif

module rr_bus_arbiter #(
    parameter int NUM_MASTERS = `INTERCON_MASTER_NUM,
    parameter int IDX_W       = $clog2(NUM_MASTERS),
    parameter int RR_MODE     = 1,
    parameter int MAX_HOLD    = 16,
    parameter int HOLD_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] request,
    input  logic [NUM_MASTERS-1:0] lock,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   grant_valid,
    output logic                   preempt
);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    localparam logic [HOLD_W-1:0]      HOLD_LIMIT = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;
    localparam logic [NUM_MASTERS-1:0] ONE_HOT_0  = NUM_MASTERS'(1);

    state_t                 state, state_nx;
    logic [IDX_W-1:0]       pointer, pointer_nx;
    logic [IDX_W-1:0]       grant_idx_nx;
    logic [NUM_MASTERS-1:0] grant_nx;
    logic [HOLD_W-1:0]      hold_cnt, hold_cnt_nx;
    logic                   preempt_nx;

    logic [NUM_MASTERS-1:0] search_mask;
    logic                   cand_found;
    logic [IDX_W-1:0]       cand;
    logic                   owner_req;
    logic                   owner_lock;
    logic                   force_handover;

    // The owner never competes against itself: it is masked out of the search,
    // which also makes it the last in line under round-robin rotation.
    assign search_mask    = request & ~grant;
    assign owner_req      = |(request & grant);
    assign owner_lock     = |(lock & grant);
    assign force_handover = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LIMIT) &&
                            !owner_lock && (|search_mask);
    assign grant_valid    = |grant;

    always_comb begin
        cand_found = 1'b0;
        cand       = '0;
        if (RR_MODE != 0) begin
            for (int k = 1; k <= NUM_MASTERS; k++) begin
                if (!cand_found && search_mask[(int'(pointer) + k) % NUM_MASTERS]) begin
                    cand_found = 1'b1;
                    cand       = IDX_W'((int'(pointer) + k) % NUM_MASTERS);
                end
            end
        end else begin
            for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
                if (search_mask[k]) begin
                    cand_found = 1'b1;
                    cand       = IDX_W'(k);
                end
            end
        end
    end

    always_comb begin
        state_nx     = state;
        grant_nx     = grant;
        grant_idx_nx = grant_idx;
        pointer_nx   = pointer;
        hold_cnt_nx  = hold_cnt;
        preempt_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (cand_found) begin
                    state_nx     = OWNED;
                    grant_nx     = ONE_HOT_0 << cand;
                    grant_idx_nx = cand;
                    pointer_nx   = cand;
                    hold_cnt_nx  = '0;
                end
            end
            OWNED: begin
                // Release wins over preemption, so preempt only pulses on a forced move.
                if (!owner_req || force_handover) begin
                    hold_cnt_nx = '0;
                    if (cand_found) begin
                        grant_nx     = ONE_HOT_0 << cand;
                        grant_idx_nx = cand;
                        pointer_nx   = cand;
                        preempt_nx   = owner_req;
                    end else begin
                        state_nx = IDLE;
                        grant_nx = '0;
                    end
                end else if (hold_cnt != '1) begin
                    hold_cnt_nx = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            pointer   <= IDX_W'(NUM_MASTERS - 1);
            hold_cnt  <= '0;
            preempt   <= 1'b0;
        end else begin
            state     <= state_nx;
            grant     <= grant_nx;
            grant_idx <= grant_idx_nx;
            pointer   <= pointer_nx;
            hold_cnt  <= hold_cnt_nx;
            preempt   <= preempt_nx;
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Self-checking bench for rr_bus_arbiter: a round-robin and a fixed-priority
// instance share stimulus; directed scenarios plus a random run against a model.
module tb_rr_bus_arbiter;

    localparam int N     = 4;
    localparam int MAXH  = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] request;
    logic [N-1:0] lock;

    logic [N-1:0] rr_grant, fp_grant;
    logic [1:0]   rr_idx, fp_idx;
    logic         rr_valid, fp_valid;
    logic         rr_pre, fp_pre;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state, index 0 = round-robin instance, 1 = fixed-priority instance.
    int m_owner[2];
    int m_idx[2];
    int m_ptr[2];
    int m_held[2];
    bit m_pre[2];

    rr_bus_arbiter #(.NUM_MASTERS(N), .IDX_W(2), .RR_MODE(1), .MAX_HOLD(MAXH), .HOLD_W(8)) u_rr (
        .clk(clk), .rst(rst), .request(request), .lock(lock),
        .grant(rr_grant), .grant_idx(rr_idx), .grant_valid(rr_valid), .preempt(rr_pre)
    );

    rr_bus_arbiter #(.NUM_MASTERS(N), .IDX_W(2), .RR_MODE(0), .MAX_HOLD(MAXH), .HOLD_W(8)) u_fp (
        .clk(clk), .rst(rst), .request(request), .lock(lock),
        .grant(fp_grant), .grant_idx(fp_idx), .grant_valid(fp_valid), .preempt(fp_pre)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void m_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1;
            m_idx[d]   = 0;
            m_ptr[d]   = N - 1;
            m_held[d]  = 0;
            m_pre[d]   = 1'b0;
        end
    endfunction

    // Round-robin: rotate the doubled mask so the slot after the pointer is bit 0.
    function automatic int pick(int d, logic [N-1:0] mask);
        logic [2*N-1:0] dbl;
        int s;
        if (mask == '0) return -1;
        if (d == 1) begin
            for (int j = 0; j < N; j++) if (mask[j]) return j;
        end
        s   = (m_ptr[d] + 1) % N;
        dbl = {mask, mask} >> s;
        for (int j = 0; j < N; j++) if (dbl[j]) return (s + j) % N;
        return -1;
    endfunction

    function automatic void m_give(int d, int c);
        m_owner[d] = c;
        m_idx[d]   = c;
        m_ptr[d]   = c;
        m_held[d]  = 0;
    endfunction

    function automatic void m_step(logic [N-1:0] req, logic [N-1:0] lk);
        logic [N-1:0] others;
        int c;
        for (int d = 0; d < 2; d++) begin
            m_pre[d] = 1'b0;
            if (m_owner[d] < 0) begin
                c = pick(d, req);
                if (c >= 0) m_give(d, c);
            end else begin
                others = req & ~(N'(1) << m_owner[d]);
                if (!req[m_owner[d]]) begin
                    c = pick(d, others);
                    if (c >= 0) m_give(d, c);
                    else begin
                        m_owner[d] = -1;
                        m_held[d]  = 0;
                    end
                end else if (m_held[d] >= MAXH - 1 && !lk[m_owner[d]] && others != '0) begin
                    m_give(d, pick(d, others));
                    m_pre[d] = 1'b1;
                end else if (m_held[d] < 255) begin
                    m_held[d]++;
                end
            end
        end
    endfunction

    // Drive at a falling edge, let one rising edge happen, return at the next falling edge.
    task automatic apply_cycle(input logic [N-1:0] req, input logic [N-1:0] lk);
        request = req;
        lock    = lk;
        @(posedge clk);
        m_step(req, lk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        request = '0;
        lock    = '0;
        @(negedge clk);
        m_reset();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        request = '0;
        lock    = '0;
        @(negedge clk);
        @(negedge clk);
        m_reset();
        n_checks++; if (rr_grant !== 4'b0000) $display("FAIL reset_grant: got %b expected 0000", rr_grant); else n_pass++;
        n_checks++; if (rr_idx !== 2'd0) $display("FAIL reset_idx: got %0d expected 0", rr_idx); else n_pass++;
        n_checks++; if (rr_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", rr_valid); else n_pass++;
        n_checks++; if (rr_pre !== 1'b0) $display("FAIL reset_preempt: got %b expected 0", rr_pre); else n_pass++;
        n_checks++; if (fp_grant !== 4'b0000) $display("FAIL reset_fp_grant: got %b expected 0000", fp_grant); else n_pass++;
        rst = 1'b1;
        apply_cycle(4'b0110, 4'b0000);
        n_checks++; if (rr_grant !== 4'b0010) $display("FAIL first_grant: got %b expected 0010", rr_grant); else n_pass++;
        n_checks++; if (rr_idx !== 2'd1) $display("FAIL first_idx: got %0d expected 1", rr_idx); else n_pass++;
        n_checks++; if (rr_valid !== 1'b1) $display("FAIL first_valid: got %b expected 1", rr_valid); else n_pass++;
        n_checks++; if (fp_grant !== 4'b0010) $display("FAIL first_fp_grant: got %b expected 0010", fp_grant); else n_pass++;
    endtask

    task automatic test_rotation();
        logic [N-1:0] exp_g;
        do_reset();
        apply_cycle(4'b1111, 4'b0000);
        n_checks++; if (rr_grant !== 4'b0001) $display("FAIL rot_start: got %b expected 0001", rr_grant); else n_pass++;
        for (int g = 0; g < N; g++) begin
            for (int c = 0; c < 2; c++) begin
                apply_cycle(4'b1111, 4'b0000);
                n_checks++; if (rr_valid !== 1'b1) $display("FAIL rot_hold_valid: got %b expected 1", rr_valid); else n_pass++;
            end
            apply_cycle(4'b1111 & ~(4'b0001 << g), 4'b0000);
            exp_g = 4'b0001 << ((g + 1) % N);
            n_checks++; if (rr_grant !== exp_g) $display("FAIL rot_grant: got %b expected %b", rr_grant, exp_g); else n_pass++;
            n_checks++; if (rr_idx !== 2'((g + 1) % N)) $display("FAIL rot_idx: got %0d expected %0d", rr_idx, (g + 1) % N); else n_pass++;
        end
    endtask

    task automatic test_preemption();
        do_reset();
        apply_cycle(4'b0001, 4'b0000);
        n_checks++; if (rr_grant !== 4'b0001) $display("FAIL pre_first: got %b expected 0001", rr_grant); else n_pass++;
        for (int c = 1; c <= 3; c++) begin
            apply_cycle(4'b0101, 4'b0000);
            n_checks++; if (rr_grant !== 4'b0001) $display("FAIL pre_hold: got %b expected 0001", rr_grant); else n_pass++;
            n_checks++; if (rr_pre !== 1'b0) $display("FAIL pre_early_pulse: got %b expected 0", rr_pre); else n_pass++;
        end
        apply_cycle(4'b0101, 4'b0000);
        n_checks++; if (rr_grant !== 4'b0100) $display("FAIL pre_move: got %b expected 0100", rr_grant); else n_pass++;
        n_checks++; if (rr_pre !== 1'b1) $display("FAIL pre_pulse: got %b expected 1", rr_pre); else n_pass++;
        n_checks++; if (fp_grant !== 4'b0100) $display("FAIL pre_fp_move: got %b expected 0100", fp_grant); else n_pass++;
        n_checks++; if (fp_pre !== 1'b1) $display("FAIL pre_fp_pulse: got %b expected 1", fp_pre); else n_pass++;
        apply_cycle(4'b0101, 4'b0000);
        n_checks++; if (rr_pre !== 1'b0) $display("FAIL pre_pulse_end: got %b expected 0", rr_pre); else n_pass++;
        n_checks++; if (rr_grant !== 4'b0100) $display("FAIL pre_after: got %b expected 0100", rr_grant); else n_pass++;
    endtask

    task automatic test_lock();
        do_reset();
        apply_cycle(4'b0001, 4'b0001);
        for (int c = 1; c <= 9; c++) begin
            apply_cycle(4'b0101, 4'b0001);
            n_checks++; if (rr_grant !== 4'b0001) $display("FAIL lock_hold: got %b expected 0001", rr_grant); else n_pass++;
            n_checks++; if (rr_pre !== 1'b0) $display("FAIL lock_pulse: got %b expected 0", rr_pre); else n_pass++;
        end
        apply_cycle(4'b0101, 4'b0000);
        n_checks++; if (rr_grant !== 4'b0100) $display("FAIL lock_release_move: got %b expected 0100", rr_grant); else n_pass++;
        n_checks++; if (rr_pre !== 1'b1) $display("FAIL lock_release_pulse: got %b expected 1", rr_pre); else n_pass++;
    endtask

    task automatic test_fixed_priority();
        do_reset();
        apply_cycle(4'b1100, 4'b0000);
        n_checks++; if (fp_grant !== 4'b0100) $display("FAIL fp_first: got %b expected 0100", fp_grant); else n_pass++;
        apply_cycle(4'b1100, 4'b0000);
        apply_cycle(4'b1010, 4'b0000);
        n_checks++; if (fp_grant !== 4'b0010) $display("FAIL fp_second: got %b expected 0010", fp_grant); else n_pass++;
        n_checks++; if (fp_pre !== 1'b0) $display("FAIL fp_release_pulse: got %b expected 0", fp_pre); else n_pass++;
        apply_cycle(4'b1010, 4'b0000);
        n_checks++; if (fp_grant !== 4'b0010) $display("FAIL fp_m3_waits: got %b expected 0010", fp_grant); else n_pass++;
        apply_cycle(4'b1000, 4'b0000);
        n_checks++; if (fp_grant !== 4'b1000) $display("FAIL fp_third: got %b expected 1000", fp_grant); else n_pass++;
        n_checks++; if (fp_idx !== 2'd3) $display("FAIL fp_third_idx: got %0d expected 3", fp_idx); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        apply_cycle(4'b1000, 4'b0000);
        n_checks++; if (rr_grant !== 4'b1000) $display("FAIL areset_owned: got %b expected 1000", rr_grant); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (rr_grant !== 4'b0000) $display("FAIL areset_grant: got %b expected 0000", rr_grant); else n_pass++;
        n_checks++; if (rr_valid !== 1'b0) $display("FAIL areset_valid: got %b expected 0", rr_valid); else n_pass++;
        n_checks++; if (fp_grant !== 4'b0000) $display("FAIL areset_fp_grant: got %b expected 0000", fp_grant); else n_pass++;
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        apply_cycle(4'b1000, 4'b0000);
        n_checks++; if (rr_grant !== 4'b1000) $display("FAIL areset_regrant: got %b expected 1000", rr_grant); else n_pass++;
        n_checks++; if (rr_idx !== 2'd3) $display("FAIL areset_regrant_idx: got %0d expected 3", rr_idx); else n_pass++;
    endtask

    task automatic test_random();
        logic [N-1:0] req, lk, exp_g;
        do_reset();
        req = '0;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            lk = N'($urandom & $urandom);
            apply_cycle(req, lk);
            exp_g = (m_owner[0] < 0) ? '0 : N'(1) << m_owner[0];
            n_checks++; if (rr_grant !== exp_g) $display("FAIL rnd_rr_grant @%0d: got %b expected %b", i, rr_grant, exp_g); else n_pass++;
            n_checks++; if (rr_idx !== 2'(m_idx[0])) $display("FAIL rnd_rr_idx @%0d: got %0d expected %0d", i, rr_idx, m_idx[0]); else n_pass++;
            n_checks++; if (rr_valid !== (m_owner[0] >= 0)) $display("FAIL rnd_rr_valid @%0d: got %b expected %b", i, rr_valid, m_owner[0] >= 0); else n_pass++;
            n_checks++; if (rr_pre !== m_pre[0]) $display("FAIL rnd_rr_preempt @%0d: got %b expected %b", i, rr_pre, m_pre[0]); else n_pass++;
            exp_g = (m_owner[1] < 0) ? '0 : N'(1) << m_owner[1];
            n_checks++; if (fp_grant !== exp_g) $display("FAIL rnd_fp_grant @%0d: got %b expected %b", i, fp_grant, exp_g); else n_pass++;
            n_checks++; if (fp_idx !== 2'(m_idx[1])) $display("FAIL rnd_fp_idx @%0d: got %0d expected %0d", i, fp_idx, m_idx[1]); else n_pass++;
            n_checks++; if (fp_valid !== (m_owner[1] >= 0)) $display("FAIL rnd_fp_valid @%0d: got %b expected %b", i, fp_valid, m_owner[1] >= 0); else n_pass++;
            n_checks++; if (fp_pre !== m_pre[1]) $display("FAIL rnd_fp_preempt @%0d: got %b expected %b", i, fp_pre, m_pre[1]); else n_pass++;
        end
    endtask

    initial begin
        rst     = 1'b0;
        request = '0;
        lock    = '0;
        m_reset();
        test_reset();
        test_rotation();
        test_preemption();
        test_lock();
        test_fixed_priority();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
